// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared CPU package for the instruction fetch path
//
// Purpose: FSM state encoding, default reset PC and instruction-width
// helpers shared by the fetch interface, the fetch unit and its bench.
// Ports: none (package).
package fetch_unit_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          WORD_W           = 32;
  localparam int          DEFAULT_CORES    = 1;
  localparam int          INSTR_W          = WORD_W * DEFAULT_CORES;

  // Instruction word width for a given core count (32*CORES).
  function automatic int instr_w(input int cores);
    return WORD_W * cores;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory and instruction-stream bundle of the fetch unit
//
// Purpose: groups the memory request/response, redirect and instruction
// handshake signals of the fetch unit.
// Signals:
//   mem_address  fetch -> memory  word address
//   mem_data     memory -> fetch  read data for the address of the previous edge
//   redirect     core -> fetch    flush and restart at redirect_pc
//   redirect_pc  core -> fetch    restart word address
//   instr_valid  fetch -> core    head entry valid
//   instr        fetch -> core    head instruction word
//   instr_pc     fetch -> core    word address of instr
//   instr_ready  core -> fetch    consumer accepts head entry
// Modports: master (fetch unit side), slave (memory/core side).
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int CORES = 1
);

  logic [31:0]               mem_address;
  logic [instr_w(CORES)-1:0] mem_data;
  logic                      redirect;
  logic [31:0]               redirect_pc;
  logic                      instr_valid;
  logic [instr_w(CORES)-1:0] instr;
  logic [31:0]               instr_pc;
  logic                      instr_ready;

  modport master (
    output mem_address,
    input  mem_data,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_address,
    output mem_data,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer FIFO of the fetch unit
//
// Purpose: DEPTH-entry FIFO (DEPTH a power of two, >= 2) holding fetched
// {instr, pc} entries; the head is presented combinationally on rdata.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (pointers/count only)
//   push, wdata      write an entry (ignored when full)
//   pop              remove the head entry (ignored when empty)
//   flush            empty the FIFO; overrides push and pop in the same cycle
//   rdata            head entry
//   full, empty      occupancy flags
//   count            number of stored entries
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset: contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with redirect and buffer
//
// Purpose: issues word-addressed fetches, captures responses one cycle later
// into a DEPTH-entry buffer and hands them to the consumer; redirect flushes
// everything and restarts at redirect_pc.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    fetch_unit_if.master (memory request/response, redirect, instr stream)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          CORES    = 1,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int IW = instr_w(CORES);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_req_pc;
  logic             r_pend;
  logic             w_issue;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_occupancy;
  logic             w_full;
  logic             w_empty;
  logic [IW+31:0]   w_head;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: IDLE lasts one cycle, RUN holds until reset.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Buffered plus in-flight entries; a same-cycle pop is deliberately not
  // credited, so the buffer can never be overrun by the pending response.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_pend};

  // Output decode: issue a request this cycle.
  always_comb begin
    w_issue = 1'b0;
    if (r_state == S_RUN && !bus.redirect && w_occupancy < (CW+1)'(DEPTH))
      w_issue = 1'b1;
  end

  // Redirect forces w_issue low, which also drops any in-flight response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (bus.redirect)  r_pc <= bus.redirect_pc;
      else if (w_issue)  r_pc <= r_pc + 32'd1;
    end
  end

  // Address of the outstanding request, paired with mem_data next cycle.
  always_ff @(posedge clk) begin
    if (w_issue) r_req_pc <= r_pc;
  end

  fetch_fifo #(
    .WIDTH (IW + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_pend),
    .pop   (bus.instr_ready),
    .flush (bus.redirect),
    .wdata ({bus.mem_data, r_req_pc}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Issue throttling makes a push into a full buffer unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.redirect) assert (!(r_pend && w_full));
  end

  assign bus.mem_address        = r_pc;
  assign bus.instr_valid        = !w_empty;
  assign {bus.instr, bus.instr_pc} = w_head;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk;
  logic rst_n;

  fetch_unit_if #(.CORES(1)) if_a ();
  fetch_unit_if #(.CORES(1)) if_b ();

  fetch_unit #(.CORES(1), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.master)
  );

  fetch_unit #(.CORES(1), .DEPTH(4), .RESET_PC(32'hFFFF_FFFE)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered instruction memory: mem[i] = i + 0x100.
  always @(posedge clk) begin
    if_a.mem_data <= if_a.mem_address + 32'h100;
    if_b.mem_data <= if_b.mem_address + 32'h100;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic v, input logic [31:0] pc);
    check({tag, " valid"}, {31'b0, if_a.instr_valid}, {31'b0, v});
    if (v) begin
      check({tag, " pc"}, if_a.instr_pc, pc);
      check({tag, " instr"}, if_a.instr, pc + 32'h100);
    end
  endtask

  task automatic do_reset(input int n_low);
    rst_n = 1'b0;
    repeat (n_low) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n            = 1'b0;
    if_a.instr_ready = 1'b0;
    if_a.redirect    = 1'b0;
    if_a.redirect_pc = 32'h0;
    if_b.instr_ready = 1'b1;
    if_b.redirect    = 1'b0;
    if_b.redirect_pc = 32'h0;

    // Streaming from reset with ready held high; DUT B checks address wrap.
    if_a.instr_ready = 1'b1;
    do_reset(2);
    check("rst mem_address", if_a.mem_address, 32'h0);
    check("rst valid", {31'b0, if_a.instr_valid}, 32'h0);
    check("rst_b mem_address", if_b.mem_address, 32'hFFFF_FFFE);
    for (int k = 0; k <= 10; k++) begin
      expect_a($sformatf("stream c%0d", k), k >= 3, 32'(k - 3));
      check($sformatf("stream addr c%0d", k), if_a.mem_address,
            (k <= 1) ? 32'h0 : 32'(k - 1));
      if (k >= 3 && k <= 6) begin
        check($sformatf("wrap valid c%0d", k), {31'b0, if_b.instr_valid}, 32'h1);
        check($sformatf("wrap pc c%0d", k), if_b.instr_pc, 32'hFFFF_FFFE + 32'(k - 3));
      end
      step();
    end

    // Backpressure: buffer fills to 4, address freezes at 4, release drains in order.
    if_a.instr_ready = 1'b0;
    do_reset(2);
    for (int k = 0; k <= 15; k++) begin
      if_a.instr_ready = (k >= 10);
      if (k < 10) expect_a($sformatf("stall c%0d", k), k >= 3, 32'h0);
      else        expect_a($sformatf("drain c%0d", k), 1'b1, 32'(k - 10));
      if (k >= 5 && k <= 10)
        check($sformatf("stall addr c%0d", k), if_a.mem_address, 32'h4);
      step();
    end

    // Redirect to 0x40 with a nearly full buffer and a response in flight.
    if_a.instr_ready = 1'b0;
    do_reset(2);
    for (int k = 0; k <= 10; k++) begin
      if_a.redirect    = (k == 5);
      if_a.redirect_pc = 32'h40;
      if_a.instr_ready = (k >= 6);
      if (k <= 5)      expect_a($sformatf("redir c%0d", k), k >= 3, 32'h0);
      else if (k <= 7) expect_a($sformatf("redir c%0d", k), 1'b0, 32'h0);
      else             expect_a($sformatf("redir c%0d", k), 1'b1, 32'h40 + 32'(k - 8));
      if (k == 6) check("redir addr c6", if_a.mem_address, 32'h40);
      step();
    end
    if_a.redirect = 1'b0;

    // Back-to-back redirects with pop asserted: only the 0x20 stream survives.
    if_a.instr_ready = 1'b1;
    do_reset(2);
    for (int k = 0; k <= 12; k++) begin
      if_a.redirect    = (k == 6 || k == 7);
      if_a.redirect_pc = (k == 6) ? 32'h10 : 32'h20;
      if (k <= 6)      expect_a($sformatf("b2b c%0d", k), k >= 3, 32'(k - 3));
      else if (k <= 9) expect_a($sformatf("b2b c%0d", k), 1'b0, 32'h0);
      else             expect_a($sformatf("b2b c%0d", k), 1'b1, 32'h20 + 32'(k - 10));
      if (k == 7) check("b2b addr c7", if_a.mem_address, 32'h10);
      if (k == 8) check("b2b addr c8", if_a.mem_address, 32'h20);
      step();
    end
    if_a.redirect = 1'b0;

    // One-cycle reset pulse mid-stream.
    do_reset(1);
    check("pulse mem_address", if_a.mem_address, 32'h0);
    for (int k = 0; k <= 4; k++) begin
      expect_a($sformatf("pulse c%0d", k), k >= 3, 32'(k - 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter CORES, default 1: number of cores; instruction word width is 32*CORES.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0: first word address fetched after reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 mem_address  output  32  word address presented to instruction memory.
REQ-007 mem_data  input  32*CORES  memory read data, equal to mem[address sampled at the previous edge].
REQ-008 redirect  input  1  branch/jump taken; flush and restart the fetch stream.
REQ-009 redirect_pc  input  32  new word address, valid while redirect=1.
REQ-010 instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
REQ-011 instr  output  32*CORES  head-of-buffer instruction word.
REQ-012 instr_pc  output  32  word address of instr.
REQ-013 instr_ready  input  1  consumer accepts; a pop occurs when instr_valid && instr_ready.

Function
REQ-014 The block SHALL address memory by word: sequential fetch increments the address by 1, with modulo-2^32 wrap from 32'hFFFFFFFF to 0.
REQ-015 mem_address SHALL be driven directly from register pc; a request is issued in a cycle when issue=1.
REQ-016 issue SHALL equal state==RUN && !redirect && (count + pend) < DEPTH, using the current-cycle count and ignoring any same-cycle pop.
REQ-017 On issue, pc SHALL advance to pc+1 and pend SHALL be set to 1 for the next cycle; otherwise pend SHALL clear and pc SHALL hold.
REQ-018 In a cycle with pend=1, mem_data and the address issued in the previous cycle (register req_pc) SHALL be written into the buffer at the edge.
REQ-019 The buffer SHALL be a FIFO of DEPTH entries holding {instr, pc}; instr_valid = (count != 0); outputs show the head entry.
REQ-020 A simultaneous push and pop SHALL leave count unchanged. Overflow is impossible by REQ-016; a push while full is a design error and SHALL be flagged by an assertion.
REQ-021 Latency: instruction address A issued in cycle n SHALL be visible on instr at cycle n+2 when the buffer was empty.
REQ-022 On redirect=1 the following SHALL all take effect at the edge:
  - count cleared, so any same-cycle pop is discarded;
  - pend cleared, so the in-flight response is dropped;
  - pc loaded with redirect_pc;
  - no request issued.
REQ-023 After redirect in cycle n: mem_address=redirect_pc in n+1; instr_valid=1 with instr_pc=redirect_pc in n+3.
REQ-024 Consecutive redirect cycles SHALL each override the previous one; the last redirect_pc wins.
REQ-025 FSM states: IDLE, RUN.
  - Reset SHALL enter IDLE.
  - IDLE SHALL go to RUN after exactly one cycle, with no issue in IDLE.
  - RUN SHALL persist until reset.
  - redirect in IDLE SHALL load pc, and the state SHALL still go to RUN.
REQ-026 With instr_ready held at 1 and no redirect, steady-state throughput SHALL be one instruction per cycle.
REQ-027 When instr_ready=0, fetch SHALL stop with exactly DEPTH entries buffered (count + pend never exceeds DEPTH).

Reset
REQ-028 When rst_n=0 at an edge, the block SHALL set:
  - state=IDLE;
  - pc=RESET_PC, so mem_address=RESET_PC;
  - pend=0, count=0 and FIFO pointers=0, so instr_valid=0.
REQ-029 Buffer data registers need no reset; instr and instr_pc are don't-care while instr_valid=0.
REQ-030 Reset asserted mid-stream SHALL discard all buffered and in-flight instructions; the first post-reset instruction SHALL be mem[RESET_PC] with instr_valid in the 4th cycle after rst_n rises.

Structure
REQ-031 The FSM state encoding and the default RESET_PC SHALL live in the shared CPU package, together with the instruction-width localparam 32*CORES.
REQ-032 The FIFO SHALL be one sub-module, fetch_fifo (parameters WIDTH, DEPTH; signals push, pop, flush, full, empty, count); all other logic stays in fetch_unit.

Verification
REQ-033 The bench SHALL model memory as a registered array with mem[i]=i+32'h100 and cover the scenarios below.
REQ-034 Reset, then ready=1 for 8 cycles -> instr_pc sequence 0,1,2,... with instr=0x100+pc, one per cycle, no gaps or duplicates.
REQ-035 ready=0 from cycle 3 -> instr_valid holds; exactly 4 entries buffered; mem_address frozen at 4 (DEPTH=4, RESET_PC=0); release -> 0..3 then 4 with no loss.
REQ-036 redirect with redirect_pc=0x40 while buffer is full and a response is pending -> all old entries dropped; 3 cycles later instr_pc=0x40, instr=0x140, then 0x41.
REQ-037 Two back-to-back redirects to 0x10 then 0x20, each with pop asserted -> only the 0x20 stream appears; 0x10 is never emitted.
REQ-038 RESET_PC=32'hFFFFFFFE, ready=1 -> instr_pc sequence FFFFFFFE, FFFFFFFF, 0, 1.
REQ-039 rst_n pulsed low for one cycle mid-stream -> instr_valid=0 the next cycle; restart from RESET_PC per REQ-030.
